// File: rtl/datapath_arbiter_pkg.sv
// rtl/datapath_arbiter_pkg.sv - shared widths and state encoding for the datapath arbiter
package datapath_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH   = 16;
    localparam int RESULT_WIDTH        = 16;
    localparam int OPCODE_WIDTH        = 4;
    localparam int REQ_COUNT           = 2;
    localparam int CYCLE_COUNT_WIDTH   = 16;
    localparam int TIMEOUT_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } state_e;

endpackage

// File: rtl/datapath_arbiter_rr_arbiter2.sv
// rtl/datapath_arbiter_rr_arbiter2.sv - two-way round-robin grant select
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // A lone requester always wins; on a tie the pointer names the preferred requester
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - shares one datapath between two requesters with timeout abort
module datapath_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [REQ_COUNT-1:0]           req_i,
    input  logic [INSTRUCTION_WIDTH-1:0]   req_instr0_i,
    input  logic [INSTRUCTION_WIDTH-1:0]   req_instr1_i,
    output logic [REQ_COUNT-1:0]           ack_o,
    output logic [REQ_COUNT-1:0]           rsp_valid_o,
    output logic [RESULT_WIDTH-1:0]        rsp_result_o,
    output logic                           rsp_error_o,
    output logic                           dp_start_o,
    output logic [INSTRUCTION_WIDTH-1:0]   dp_instruction_o,
    input  logic                           dp_finished_i,
    input  logic [RESULT_WIDTH-1:0]        dp_result_i,
    output logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_o
);

    localparam logic [CYCLE_COUNT_WIDTH-1:0] TIMEOUT_LAST = CYCLE_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                         state_q;
    logic                           ptr_q;
    logic [REQ_COUNT-1:0]           gnt_q;
    logic [CYCLE_COUNT_WIDTH-1:0]   cycle_cnt_q;
    logic [REQ_COUNT-1:0]           rsp_valid_q;
    logic [RESULT_WIDTH-1:0]        rsp_result_q;
    logic                           rsp_error_q;
    logic                           dp_start_q;
    logic [INSTRUCTION_WIDTH-1:0]   dp_instruction_q;
    logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_q;

    logic [REQ_COUNT-1:0] arb_grant;
    logic                 grant_take;
    logic                 abort;

    rr_arbiter2 u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant)
    );

    // Grant decision and timeout abort; ack is held low while reset is asserted
    always_comb begin
        grant_take = (state_q == ST_IDLE) && dp_finished_i && (req_i != '0) && !reset_i;
        abort      = (cycle_cnt_q == TIMEOUT_LAST) &&
                     ((state_q == ST_WAIT_BUSY) || ((state_q == ST_WAIT_DONE) && !dp_finished_i));
        ack_o      = grant_take ? arb_grant : '0;
    end

    // Single-outstanding FSM: grant, one start pulse, see busy, see done, respond
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            ptr_q            <= 1'b0;
            gnt_q            <= '0;
            cycle_cnt_q      <= '0;
            rsp_valid_q      <= '0;
            rsp_result_q     <= '0;
            rsp_error_q      <= 1'b0;
            dp_start_q       <= 1'b0;
            dp_instruction_q <= '0;
            timeout_count_q  <= '0;
        end else begin
            dp_start_q  <= 1'b0;
            rsp_valid_q <= '0;
            if (abort) begin
                rsp_result_q <= '0;
                rsp_error_q  <= 1'b1;
                rsp_valid_q  <= gnt_q;
                if (timeout_count_q != '1) begin
                    timeout_count_q <= timeout_count_q + 1'b1;
                end
                state_q <= ST_RESPOND;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (grant_take) begin
                            gnt_q            <= arb_grant;
                            ptr_q            <= arb_grant[0];
                            dp_instruction_q <= arb_grant[1] ? req_instr1_i : req_instr0_i;
                            dp_start_q       <= 1'b1;
                            state_q          <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        cycle_cnt_q <= '0;
                        state_q     <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                        if (!dp_finished_i) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                        if (dp_finished_i) begin
                            rsp_result_q <= dp_result_i;
                            rsp_error_q  <= 1'b0;
                            rsp_valid_q  <= gnt_q;
                            state_q      <= ST_RESPOND;
                        end
                    end
                    ST_RESPOND: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = rsp_result_q;
    assign rsp_error_o      = rsp_error_q;
    assign dp_start_o       = dp_start_q;
    assign dp_instruction_o = dp_instruction_q;
    assign timeout_count_o  = timeout_count_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - directed vector bench for datapath_arbiter
module tb_datapath_arbiter;
    import datapath_arbiter_pkg::*;

    localparam int T_CYC = 8;

    logic                           clk = 1'b0;
    logic                           reset_i;
    logic [1:0]                     req_i;
    logic [INSTRUCTION_WIDTH-1:0]   req_instr0_i, req_instr1_i;
    logic [1:0]                     ack_o, rsp_valid_o;
    logic [RESULT_WIDTH-1:0]        rsp_result_o;
    logic                           rsp_error_o, dp_start_o;
    logic [INSTRUCTION_WIDTH-1:0]   dp_instruction_o;
    logic                           dp_finished = 1'b1;
    logic [RESULT_WIDTH-1:0]        dp_result = '0;
    logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    int                    busy_n = 1;
    int                    busy_left = 0;
    bit                    never_drop = 1'b0;
    logic [RESULT_WIDTH-1:0] dp_ret = '0;

    datapath_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clock_i          (clk),
        .reset_i          (reset_i),
        .req_i            (req_i),
        .req_instr0_i     (req_instr0_i),
        .req_instr1_i     (req_instr1_i),
        .ack_o            (ack_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_result_o     (rsp_result_o),
        .rsp_error_o      (rsp_error_o),
        .dp_start_o       (dp_start_o),
        .dp_instruction_o (dp_instruction_o),
        .dp_finished_i    (dp_finished),
        .dp_result_i      (dp_result),
        .timeout_count_o  (timeout_count_o)
    );

    always #5 clk = ~clk;

    // Datapath model: on start drop finished for busy_n cycles then present dp_ret
    always @(posedge clk) begin
        if (dp_start_o && !never_drop) begin
            dp_finished <= 1'b0;
            busy_left   <= busy_n;
            dp_result   <= dp_ret;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else if (busy_left == 1) begin
            busy_left   <= 0;
            dp_finished <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s ack", tag), 32'(ack_o), 0);
        chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid_o), 0);
        chk($sformatf("%s rsp_result", tag), 32'(rsp_result_o), 0);
        chk($sformatf("%s rsp_error", tag), 32'(rsp_error_o), 0);
        chk($sformatf("%s dp_start", tag), 32'(dp_start_o), 0);
        chk($sformatf("%s dp_instruction", tag), 32'(dp_instruction_o), 0);
        chk($sformatf("%s timeout_count", tag), 32'(timeout_count_o), 0);
    endtask

    // Called at a negedge; one full transaction from request to response
    task automatic run_txn(input string tag, input logic [1:0] rq,
                           input logic [15:0] i0, input logic [15:0] i1,
                           input int busy, input logic [15:0] ret, input bit never,
                           input logic [1:0] exp_g, input int exp_lat,
                           input logic exp_err, input logic [15:0] exp_res);
        logic [15:0] exp_instr;
        logic [1:0]  g;
        int lat, starts, extra, instr_bad;
        bit got;
        exp_instr = exp_g[1] ? i1 : i0;
        busy_n = busy; dp_ret = ret; never_drop = never;
        req_instr0_i = i0; req_instr1_i = i1; req_i = rq;
        got = 1'b0;
        g = '0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (ack_o != 0) begin
                got = 1'b1;
                g = ack_o;
            end else begin
                @(negedge clk);
            end
        end
        chk($sformatf("%s ack", tag), 32'(g), 32'(exp_g));
        if (!got) begin
            req_i = '0;
            return;
        end
        @(posedge clk);
        #1;
        req_i = req_i & ~g;
        lat = 0; starts = 0; extra = 0; instr_bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (dp_start_o) starts++;
            if (ack_o != 0) extra++;
            if (dp_instruction_o !== exp_instr) instr_bad++;
        end while (rsp_valid_o == 0 && lat < 60);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s start_pulses", tag), 32'(starts), 1);
        chk($sformatf("%s extra_ack", tag), 32'(extra), 0);
        chk($sformatf("%s instr_stable", tag), 32'(instr_bad), 0);
        chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid_o), 32'(exp_g));
        chk($sformatf("%s rsp_error", tag), 32'(rsp_error_o), 32'(exp_err));
        chk($sformatf("%s rsp_result", tag), 32'(rsp_result_o), 32'(exp_res));
        req_i = '0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] i0;
        logic [15:0] i1;
        int          busy;
        logic [15:0] ret;
        logic [1:0]  grant;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{2'b11, 16'h1111, 16'h2222, 2, 16'h00A1, 2'b01};
        vecs[1] = '{2'b11, 16'h1133, 16'h2244, 1, 16'hBEEF, 2'b10};
        vecs[2] = '{2'b11, 16'h3001, 16'h4002, 3, 16'h0001, 2'b01};
        vecs[3] = '{2'b11, 16'h3003, 16'h4004, 2, 16'hFFFF, 2'b10};
        vecs[4] = '{2'b10, 16'h5005, 16'h6006, 1, 16'h1234, 2'b10};
        vecs[5] = '{2'b01, 16'h2034, 16'h7007, 3, 16'h000F, 2'b01};
        vecs[6] = '{2'b01, 16'h0ABC, 16'h8008, 1, 16'h5A5A, 2'b01};
        vecs[7] = '{2'b11, 16'h9009, 16'hA00A, 4, 16'h0F0F, 2'b10};

        reset_i = 1'b1;
        req_i = 2'b11;
        req_instr0_i = 16'hDEAD;
        req_instr1_i = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        req_i = '0;
        reset_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("row%0d", i), vecs[i].req, vecs[i].i0, vecs[i].i1,
                    vecs[i].busy, vecs[i].ret, 1'b0, vecs[i].grant,
                    3 + vecs[i].busy, 1'b0, vecs[i].ret);
        end

        run_txn("timeout", 2'b01, 16'hC00C, 16'hD00D, 1, 16'h7777, 1'b1,
                2'b01, T_CYC + 2, 1'b1, 16'h0000);
        chk("timeout count", 32'(timeout_count_o), 1);
        run_txn("after_timeout", 2'b10, 16'hE00E, 16'hF00F, 2, 16'h4321, 1'b0,
                2'b10, 5, 1'b0, 16'h4321);

        busy_n = 5; dp_ret = 16'h3C3C; never_drop = 1'b0;
        req_instr0_i = 16'h7ABC; req_instr1_i = 16'h1234; req_i = 2'b01;
        cnt = 0;
        while (ack_o == 0 && cnt < 40) begin
            #1;
            if (ack_o == 0) @(negedge clk);
            cnt++;
        end
        chk("midreset ack", 32'(ack_o), 1);
        @(posedge clk);
        #1;
        req_i = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ack_o != 0 || rsp_valid_o != 0) cnt++;
        end
        chk("post_reset quiet", 32'(cnt), 0);
        run_txn("post_reset_tie", 2'b11, 16'h0101, 16'h0202, 2, 16'h9999, 1'b0,
                2'b01, 5, 1'b0, 16'h9999);

        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            run_txn($sformatf("sat%0d", n), 2'b01, 16'h1000, 16'h2000, 1, 16'h5555,
                    1'b1, 2'b01, T_CYC + 2, 1'b1, 16'h0000);
            if (n == 254) chk("timeout count 255", 32'(timeout_count_o), 255);
        end
        chk("timeout count saturated", 32'(timeout_count_o), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles a granted instruction may stay outstanding before abort.
REQ-002 Parameter: widths INSTRUCTION_WIDTH, RESULT_WIDTH and OPCODE_WIDTH SHALL come from the shared constants, never be redeclared locally.
REQ-003 Port: clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  2  per-requester request; held high with instruction stable until matching ack.
REQ-006 Port: req_instr0, req_instr1  in  INSTRUCTION_WIDTH each  instruction from requester 0/1.
REQ-007 Port: ack  out  2  one-cycle pulse; instruction of that requester latched.
REQ-008 Port: rsp_valid  out  2  one-cycle pulse; response for that requester present.
REQ-009 Port: rsp_result  out  RESULT_WIDTH  result; valid only while any rsp_valid bit is high.
REQ-010 Port: rsp_error  out  1  qualifies rsp_valid; 1 = timed out, rsp_result = 0.
REQ-011 Port: dp_start, dp_instruction  out  1, INSTRUCTION_WIDTH  drive datapath start/instruction.
REQ-012 Port: dp_finished, dp_result  in  1, RESULT_WIDTH  datapath idle flag and result.
REQ-013 Port: timeout_count  out  8  saturating count of aborted instructions.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND; exactly one instruction outstanding at a time.
REQ-015 IDLE: when dp_finished=1 and req!=0, grant one requester, latch its instruction into dp_instruction, pulse ack for that bit the same cycle, go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; after reset requester 0 wins the first tie.
REQ-017 A single requester SHALL be granted regardless of round-robin pointer; the pointer updates only on grant.
REQ-018 ISSUE: dp_start=1 for exactly this one cycle, dp_instruction held stable; then WAIT_BUSY.
REQ-019 WAIT_BUSY: on dp_finished=0 go to WAIT_DONE; an instruction the datapath completes without ever dropping finished is not supported and SHALL resolve through timeout.
REQ-020 WAIT_DONE: on dp_finished=1 capture dp_result into rsp_result, go to RESPOND.
REQ-021 RESPOND: pulse rsp_valid for the granted requester with rsp_error=0; return to IDLE; earliest next grant is the following cycle.
REQ-022 dp_instruction SHALL hold its value from ISSUE through RESPOND; dp_start SHALL be 0 outside ISSUE.
REQ-023 A cycle counter SHALL clear on entering WAIT_BUSY and increment in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES go to RESPOND with rsp_error=1, rsp_result=0, increment timeout_count (saturate at 255).
REQ-024 Result SHALL be forwarded for every opcode; meaning of result is the requester's concern.
REQ-025 Request dropped before ack SHALL be treated as never made; req changes while not IDLE SHALL be ignored.
REQ-026 Minimum grant-to-rsp_valid latency SHALL be 4 cycles (ack, start, busy seen, done seen) plus datapath busy time.

Reset
REQ-027 On reset: state IDLE, ack=0, rsp_valid=0, rsp_result=0, rsp_error=0, dp_start=0, dp_instruction=0, timeout_count=0, RR pointer to requester 0, counter 0.
REQ-028 Reset mid-operation SHALL abandon the outstanding instruction without response; no ack or rsp_valid pulse SHALL follow reset release until a new request.

Structure
REQ-029 State encoding and widths SHALL live in the shared constants package alongside the datapath widths.
REQ-030 Round-robin select SHALL be a sub-module rr_arbiter2 (req[1:0], pointer -> grant[1:0]).

Verification
REQ-031 Req0 only, opcode 2, datapath model returns 15 -> ack[0] one cycle, one dp_start pulse, rsp_valid[0] with rsp_result=15, rsp_error=0.
REQ-032 Req0 and req1 simultaneously after reset -> grant order 0 then 1; both again -> 0 then 1 alternate; no overlapping dp_start.
REQ-033 Datapath model never drops finished, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_error=1, rsp_result=0, timeout_count=1; next request served normally.
REQ-034 Reset asserted in WAIT_DONE -> all outputs zero asynchronously; no rsp_valid after release; new req0 served with ack.
REQ-035 Invalid opcode 0 (datapath drops finished one cycle) -> rsp_valid at minimum latency of 4 cycles after ack.
REQ-036 300 consecutive timeouts -> timeout_count saturates at 255.
